// File: rtl/div_issue_pkg.sv
// -----------------------------------------------------------------------------
// div_issue_pkg
// Shared types and helpers for the divider issue controller: FSM state enum,
// req_op encodings, the operand/result widths and the cache key layout, plus
// the quotient/remainder select and W-variant sign-extension helper.
// -----------------------------------------------------------------------------
package div_issue_pkg;

    localparam int XLEN      = 64;
    localparam int DIV_RES_W = 128;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } div_state_e;

    // req_op[0] marks the unsigned forms, req_op[1] marks the remainder forms.
    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    // Everything that determines the divider's raw {remainder, quotient}.
    // DIV and REM on the same operands share a key, which is what makes the
    // cache useful for the usual DIV/REM pair.
    typedef struct packed {
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic            sign;
        logic            w;
    } div_key_t;

    // Pick the quotient or remainder half of the divider output. W variants
    // always sign-extend bit 31, including the unsigned W forms.
    function automatic logic [XLEN-1:0] format_result(
        input logic [DIV_RES_W-1:0] res,
        input logic                 is_rem,
        input logic                 w
    );
        logic [XLEN-1:0] sel;
        logic [XLEN-1:0] out;
        sel = is_rem ? res[DIV_RES_W-1:XLEN] : res[XLEN-1:0];
        if (w) begin
            out = {{(XLEN-32){sel[31]}}, sel[31:0]};
        end else begin
            out = sel;
        end
        return out;
    endfunction

endpackage

// File: rtl/div_issue_ctrl_cache.sv
// -----------------------------------------------------------------------------
// div_result_cache
// One-entry store holding the last raw divider result and the key it was
// computed for. The key is registered; a lookup compares the live request key
// against it in the same cycle so a hit can skip the divider entirely.
// With CACHE_EN=0 the entry is never reported as a hit.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset (clears the valid bit)
//   lookup_key   key of the request currently presented by EX
//   hit          lookup_key matches a valid stored entry
//   hit_data     stored raw {remainder, quotient}
//   upd_en       strobe: store upd_key/upd_data this cycle
//   upd_key      key of the operation the divider just finished
//   upd_data     raw divider result to store
// -----------------------------------------------------------------------------
module div_result_cache
    import div_issue_pkg::*;
#(
    parameter bit CACHE_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  div_key_t             lookup_key,
    output logic                 hit,
    output logic [DIV_RES_W-1:0] hit_data,
    input  logic                 upd_en,
    input  div_key_t             upd_key,
    input  logic [DIV_RES_W-1:0] upd_data
);

    logic                 valid_q, valid_d;
    div_key_t             key_q, key_d;
    logic [DIV_RES_W-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        key_d   = key_q;
        data_d  = data_q;
        if (upd_en) begin
            valid_d = 1'b1;
            key_d   = upd_key;
            data_d  = upd_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            key_q   <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            key_q   <= key_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        hit      = CACHE_EN && valid_q && (key_q == lookup_key);
        hit_data = data_q;
    end

endmodule

// File: rtl/div_issue_ctrl.sv
// -----------------------------------------------------------------------------
// div_issue_ctrl
// Execute-stage initiator for the multi-cycle radix-2 divider. Accepts a
// DIV/DIVU/REM/REMU (optionally W) op from EX, stalls the pipeline while the
// divider runs, holds stable registered operands on the divider interface and
// returns one registered, formatted result. A one-entry result cache lets the
// second op of a DIV/REM pair on identical operands finish without the divider.
//
// Ports:
//   clk, rst                clock, asynchronous active-high reset
//   req_valid               EX holds a divide-class op (held while stalled)
//   req_op, req_w           operation select and W-variant flag
//   req_rs1, req_rs2        dividend, divisor
//   flush                   kill the current instruction
//   stall_req               freeze EX and earlier stages
//   resp_valid, resp_data   one-cycle result strobe and rd write value
//   div_valid               request to the divider
//   div_sign, div_32        signed / W operation to the divider
//   div_rs1, div_rs2        registered operands to the divider
//   div_ready, div_result   divider completion and {remainder, quotient}
// -----------------------------------------------------------------------------
module div_issue_ctrl
    import div_issue_pkg::*;
#(
    parameter int XLEN     = div_issue_pkg::XLEN,
    parameter bit CACHE_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    input  logic [1:0]           req_op,
    input  logic                 req_w,
    input  logic [XLEN-1:0]      req_rs1,
    input  logic [XLEN-1:0]      req_rs2,
    input  logic                 flush,
    output logic                 stall_req,
    output logic                 resp_valid,
    output logic [XLEN-1:0]      resp_data,
    output logic                 div_valid,
    output logic                 div_sign,
    output logic                 div_32,
    output logic [XLEN-1:0]      div_rs1,
    output logic [XLEN-1:0]      div_rs2,
    input  logic                 div_ready,
    input  logic [DIV_RES_W-1:0] div_result
);

    div_state_e state_q, state_d;

    logic            rem_q, rem_d;
    logic            w_q, w_d;
    logic            sign_q, sign_d;
    logic [XLEN-1:0] rs1_q, rs1_d;
    logic [XLEN-1:0] rs2_q, rs2_d;
    logic [XLEN-1:0] resp_data_q, resp_data_d;

    logic                 accept;
    logic                 div_done;
    logic                 cache_hit;
    logic [DIV_RES_W-1:0] cache_data;
    div_key_t             lookup_key;
    div_key_t             upd_key;

    // The cache is keyed on the raw divide (operands, signedness, width), so
    // the live request key is compared on acceptance and the registered
    // operands are stored whenever the divider hands back a result.
    always_comb begin
        lookup_key.rs1  = req_rs1;
        lookup_key.rs2  = req_rs2;
        lookup_key.sign = ~req_op[0];
        lookup_key.w    = req_w;
        upd_key.rs1     = rs1_q;
        upd_key.rs2     = rs2_q;
        upd_key.sign    = sign_q;
        upd_key.w       = w_q;
    end

    div_result_cache #(
        .CACHE_EN (CACHE_EN)
    ) u_cache (
        .clk        (clk),
        .rst        (rst),
        .lookup_key (lookup_key),
        .hit        (cache_hit),
        .hit_data   (cache_data),
        .upd_en     (div_done),
        .upd_key    (upd_key),
        .upd_data   (div_result)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A flush while the divider is still working cannot abort it, so the
    // op is parked in DRAIN until the divider finishes. A flush coinciding
    // with div_ready has nothing left to wait for and returns to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && !flush) begin
                    state_d = cache_hit ? ST_DONE : ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (div_ready) begin
                    state_d = flush ? ST_IDLE : ST_DONE;
                end else if (flush) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (div_ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // div_valid stays high through DRAIN: dropping it would freeze the
    // divider's iteration counter. While draining, EX is only stalled if it
    // already presents the next divide, which then waits for IDLE.
    always_comb begin
        accept     = (state_q == ST_IDLE) && req_valid && !flush;
        div_valid  = (state_q == ST_BUSY) || (state_q == ST_DRAIN);
        div_done   = div_valid && div_ready;
        resp_valid = (state_q == ST_DONE) && !flush;
        stall_req  = accept
                   || (state_q == ST_BUSY)
                   || ((state_q == ST_DRAIN) && req_valid);
    end

    // Operands are captured once on acceptance and held until the next
    // acceptance so the divider sees them stable for the whole iteration.
    // A cache hit formats with the live op since the stored entry may have
    // been produced by the partner DIV/REM op.
    always_comb begin
        rem_d       = rem_q;
        w_d         = w_q;
        sign_d      = sign_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        resp_data_d = resp_data_q;
        if (accept) begin
            rem_d  = req_op[1];
            w_d    = req_w;
            sign_d = ~req_op[0];
            rs1_d  = req_rs1;
            rs2_d  = req_rs2;
            if (cache_hit) begin
                resp_data_d = format_result(cache_data, req_op[1], req_w);
            end
        end else if ((state_q == ST_BUSY) && div_ready) begin
            resp_data_d = format_result(div_result, rem_q, w_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q       <= 1'b0;
            w_q         <= 1'b0;
            sign_q      <= 1'b0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            resp_data_q <= '0;
        end else begin
            rem_q       <= rem_d;
            w_q         <= w_d;
            sign_q      <= sign_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            resp_data_q <= resp_data_d;
        end
    end

    assign resp_data = resp_data_q;
    assign div_sign  = sign_q;
    assign div_32    = w_q;
    assign div_rs1   = rs1_q;
    assign div_rs2   = rs2_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_div_issue_ctrl
// Two controllers share one stimulus stream: u_dut with the result cache and
// u_dut_nc without it. Each has its own divider stand-in that answers after
// 67 valid cycles, or after one for divide-by-zero and signed overflow.
// The bench predicts every op's latency from its own cache bookkeeping and
// computes each rd value with plain arithmetic; a negedge process compares
// the selected controller against those predictions every cycle.
// -----------------------------------------------------------------------------
module tb_div_issue_ctrl;
    import div_issue_pkg::*;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic [1:0]  req_op;
    logic        req_w;
    logic [63:0] req_rs1;
    logic [63:0] req_rs2;
    logic        flush;

    logic         o_stall[2];
    logic         o_resp_valid[2];
    logic [63:0]  o_resp_data[2];
    logic         o_div_valid[2];
    logic         o_div_sign[2];
    logic         o_div_32[2];
    logic [63:0]  o_rs1[2];
    logic [63:0]  o_rs2[2];
    logic         d_ready[2];
    logic [127:0] d_result[2];

    int n_compared   = 0;
    int n_mismatched = 0;

    bit sel;
    bit cache_en;
    bit check_en;

    logic        exp_stall;
    logic        exp_dv;
    logic        exp_rv;
    logic [63:0] exp_data;
    logic [63:0] exp_rs1;
    logic [63:0] exp_rs2;
    logic        exp_sign;
    logic        exp_w;

    logic        c_valid;
    logic [63:0] c_rs1;
    logic [63:0] c_rs2;
    logic        c_sign;
    logic        c_w;

    div_issue_ctrl #(.XLEN(64), .CACHE_EN(1'b1)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .req_w      (req_w),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .flush      (flush),
        .stall_req  (o_stall[0]),
        .resp_valid (o_resp_valid[0]),
        .resp_data  (o_resp_data[0]),
        .div_valid  (o_div_valid[0]),
        .div_sign   (o_div_sign[0]),
        .div_32     (o_div_32[0]),
        .div_rs1    (o_rs1[0]),
        .div_rs2    (o_rs2[0]),
        .div_ready  (d_ready[0]),
        .div_result (d_result[0])
    );

    div_issue_ctrl #(.XLEN(64), .CACHE_EN(1'b0)) u_dut_nc (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .req_w      (req_w),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .flush      (flush),
        .stall_req  (o_stall[1]),
        .resp_valid (o_resp_valid[1]),
        .resp_data  (o_resp_data[1]),
        .div_valid  (o_div_valid[1]),
        .div_sign   (o_div_sign[1]),
        .div_32     (o_div_32[1]),
        .div_rs1    (o_rs1[1]),
        .div_rs2    (o_rs2[1]),
        .div_ready  (d_ready[1]),
        .div_result (d_result[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Divide-by-zero and signed overflow are answered by the divider at once.
    function automatic logic isSpecial(input logic sgn, input logic w,
                                       input logic [63:0] a, input logic [63:0] b);
        logic s;
        if (w) begin
            s = (b[31:0] == 32'h0) ||
                (sgn && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
        end else begin
            s = (b == 64'h0) ||
                (sgn && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF);
        end
        return s;
    endfunction

    // Raw divider output {remainder, quotient}; W results sit zero-extended
    // in the low 32 bits of each half, as the real divider produces them.
    function automatic logic [127:0] rawDiv(input logic sgn, input logic w,
                                            input logic [63:0] a, input logic [63:0] b);
        logic [63:0] q;
        logic [63:0] r;
        logic [31:0] a32;
        logic [31:0] b32;
        logic [31:0] q32;
        logic [31:0] r32;
        a32 = a[31:0];
        b32 = b[31:0];
        if (w) begin
            if (b32 == 32'h0) begin
                q32 = 32'hFFFF_FFFF;
                r32 = a32;
            end else if (sgn && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
                q32 = a32;
                r32 = 32'h0;
            end else if (sgn) begin
                q32 = $signed(a32) / $signed(b32);
                r32 = $signed(a32) % $signed(b32);
            end else begin
                q32 = a32 / b32;
                r32 = a32 % b32;
            end
            q = {32'h0, q32};
            r = {32'h0, r32};
        end else begin
            if (b == 64'h0) begin
                q = 64'hFFFF_FFFF_FFFF_FFFF;
                r = a;
            end else if (sgn && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) begin
                q = a;
                r = 64'h0;
            end else if (sgn) begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end else begin
                q = a / b;
                r = a % b;
            end
        end
        return {r, q};
    endfunction

    // Architectural rd value of an RV64M divide-class op.
    function automatic logic [63:0] refRd(input logic [1:0] op, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
        logic [127:0] res;
        logic [63:0]  v;
        res = rawDiv(!op[0], w, a, b);
        v   = op[1] ? res[127:64] : res[63:0];
        if (w) begin
            v = {{32{v[31]}}, v[31:0]};
        end
        return v;
    endfunction

    // One divider stand-in per controller: counts valid cycles and answers
    // combinationally on the 67th (first, for the special cases).
    for (genvar g = 0; g < 2; g++) begin : g_div
        logic [6:0] cnt;
        logic       spec;

        assign spec        = isSpecial(o_div_sign[g], o_div_32[g], o_rs1[g], o_rs2[g]);
        assign d_ready[g]  = o_div_valid[g] && (cnt == (spec ? 7'd0 : 7'd66));
        assign d_result[g] = d_ready[g] ? rawDiv(o_div_sign[g], o_div_32[g], o_rs1[g], o_rs2[g])
                                        : {2{64'hDEAD_BEEF_DEAD_BEEF}};

        always @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt <= 7'd0;
            end else if (o_div_valid[g]) begin
                cnt <= d_ready[g] ? 7'd0 : cnt + 7'd1;
            end
        end
    end

    task automatic checkOutput(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_compared++;
        if (act !== expv) begin
            n_mismatched++;
            $display("[TB] FAIL %s at t=%0t: got 0x%h, expected 0x%h", nm, $time, act, expv);
        end
    endtask

    // Per-cycle comparison of the selected controller against the prediction.
    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("stall_req", 64'(o_stall[sel]), 64'(exp_stall));
            checkOutput("div_valid", 64'(o_div_valid[sel]), 64'(exp_dv));
            checkOutput("resp_valid", 64'(o_resp_valid[sel]), 64'(exp_rv));
            if (exp_rv) begin
                checkOutput("resp_data", o_resp_data[sel], exp_data);
            end
            if (exp_dv) begin
                checkOutput("div_rs1", o_rs1[sel], exp_rs1);
                checkOutput("div_rs2", o_rs2[sel], exp_rs2);
                checkOutput("div_sign", 64'(o_div_sign[sel]), 64'(exp_sign));
                checkOutput("div_32", 64'(o_div_32[sel]), 64'(exp_w));
            end
        end
    end

    task automatic applyStimulus(input logic v, input logic [1:0] op, input logic w,
                                 input logic [63:0] a, input logic [63:0] b, input logic fl);
        req_valid = v;
        req_op    = op;
        req_w     = w;
        req_rs1   = a;
        req_rs2   = b;
        flush     = fl;
    endtask

    // Publish this cycle's expectations, optionally pin resp_data to a
    // hand-computed literal, then advance to just after the next rising edge.
    task automatic stepCycle(input logic e_stall, input logic e_dv, input logic e_rv,
                             input logic [63:0] e_data, input logic [63:0] e_rs1,
                             input logic [63:0] e_rs2, input logic e_sign, input logic e_w,
                             input logic do_lit, input logic [63:0] lit, input string nm);
        exp_stall = e_stall;
        exp_dv    = e_dv;
        exp_rv    = e_rv;
        exp_data  = e_data;
        exp_rs1   = e_rs1;
        exp_rs2   = e_rs2;
        exp_sign  = e_sign;
        exp_w     = e_w;
        check_en  = 1'b1;
        @(negedge clk);
        #1;
        if (do_lit) begin
            checkOutput(nm, o_resp_data[sel], lit);
        end
        @(posedge clk);
        #1;
    endtask

    // Issue one op from IDLE and follow it to its response. Latency is 1 on a
    // predicted cache hit, 2 for the divider's immediate cases, 68 otherwise.
    task automatic runOp(input logic [1:0] op, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] lit, input string nm);
        logic        sgn;
        logic        hit;
        int          lat;
        logic [63:0] e;
        sgn = !op[0];
        hit = cache_en && c_valid && c_rs1 == a && c_rs2 == b && c_sign == sgn && c_w == w;
        lat = hit ? 1 : (isSpecial(sgn, w, a, b) ? 2 : 68);
        e   = refRd(op, w, a, b);
        applyStimulus(1'b1, op, w, a, b, 1'b0);
        for (int k = 0; k <= lat; k++) begin
            stepCycle(k < lat, k >= 1 && k < lat, k == lat, e, a, b, sgn, w, k == lat, lit, nm);
        end
        if (!hit) begin
            c_valid = 1'b1;
            c_rs1   = a;
            c_rs2   = b;
            c_sign  = sgn;
            c_w     = w;
        end
        applyStimulus(1'b0, op, w, a, b, 1'b0);
    endtask

    task automatic checkResetValues();
        checkOutput("rst_stall_req", 64'(o_stall[sel]), 64'h0);
        checkOutput("rst_div_valid", 64'(o_div_valid[sel]), 64'h0);
        checkOutput("rst_resp_valid", 64'(o_resp_valid[sel]), 64'h0);
        checkOutput("rst_resp_data", o_resp_data[sel], 64'h0);
        checkOutput("rst_div_rs1", o_rs1[sel], 64'h0);
        checkOutput("rst_div_rs2", o_rs2[sel], 64'h0);
        checkOutput("rst_div_sign", 64'(o_div_sign[sel]), 64'h0);
        checkOutput("rst_div_32", 64'(o_div_32[sel]), 64'h0);
    endtask

    // Asserts rst between edges, checks the asynchronous clear, holds it
    // across one rising edge and releases it just after that edge.
    task automatic doReset();
        check_en = 1'b0;
        applyStimulus(1'b0, OP_DIV, 1'b0, 64'h0, 64'h0, 1'b0);
        rst = 1'b1;
        #1;
        checkResetValues();
        @(posedge clk);
        #1;
        rst     = 1'b0;
        c_valid = 1'b0;
    endtask

    initial begin
        rst      = 1'b0;
        sel      = 1'b0;
        cache_en = 1'b1;
        check_en = 1'b0;
        c_valid  = 1'b0;
        c_rs1    = 64'h0;
        c_rs2    = 64'h0;
        c_sign   = 1'b0;
        c_w      = 1'b0;
        applyStimulus(1'b0, OP_DIV, 1'b0, 64'h0, 64'h0, 1'b0);
        #1;
        doReset();

        $display("[TB] cached controller: basic and corner divides");
        runOp(OP_DIV,  1'b0, 64'd100, 64'd7, 64'd14, "div_100_7");
        runOp(OP_REM,  1'b0, 64'd100, 64'd7, 64'd2,  "rem_100_7_hit");
        runOp(OP_DIV,  1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, "div_m7_2");
        runOp(OP_REM,  1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, "rem_m7_2_hit");
        runOp(OP_DIVU, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, "divu_5_0");
        runOp(OP_REMU, 1'b0, 64'd5, 64'd0, 64'd5, "remu_5_0");
        runOp(OP_DIV,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
              64'h8000_0000_0000_0000, "div_ovf");
        runOp(OP_REM,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
              64'h0, "rem_ovf");
        runOp(OP_DIV,  1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
              64'hFFFF_FFFF_8000_0000, "divw_ovf");
        runOp(OP_DIVU, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1,
              64'hFFFF_FFFF_FFFF_FFFF, "divuw_sext");
        runOp(OP_DIV,  1'b0, 64'd9, 64'd3, 64'd3, "div_9_3");

        $display("[TB] reset in the middle of a divide");
        applyStimulus(1'b1, OP_DIVU, 1'b0, 64'd1000, 64'd3, 1'b0);
        for (int k = 0; k < 30; k++) begin
            stepCycle(1'b1, k >= 1, 1'b0, 64'h0, 64'd1000, 64'd3, 1'b0, 1'b0, 1'b0, 64'h0, "");
        end
        doReset();
        runOp(OP_DIV, 1'b0, 64'd9, 64'd3, 64'd3, "div_9_3_after_rst");

        $display("[TB] flush while busy, next op waits for drain");
        applyStimulus(1'b1, OP_DIV, 1'b0, 64'd1000, 64'd7, 1'b0);
        for (int k = 0; k < 68; k++) begin
            if (k == 10) begin
                applyStimulus(1'b1, OP_DIV, 1'b0, 64'd1000, 64'd7, 1'b1);
            end else if (k > 10 && k < 20) begin
                applyStimulus(1'b0, OP_DIV, 1'b0, 64'd1000, 64'd7, 1'b0);
            end else if (k >= 20) begin
                applyStimulus(1'b1, OP_DIVU, 1'b0, 64'd1000, 64'd10, 1'b0);
            end
            stepCycle(k <= 10 || k >= 20, k >= 1, 1'b0, 64'h0, 64'd1000, 64'd7,
                      1'b1, 1'b0, 1'b0, 64'h0, "");
        end
        c_valid = 1'b1;
        c_rs1   = 64'd1000;
        c_rs2   = 64'd7;
        c_sign  = 1'b1;
        c_w     = 1'b0;
        runOp(OP_DIVU, 1'b0, 64'd1000, 64'd10, 64'd100, "divu_after_drain");

        $display("[TB] uncached controller");
        check_en = 1'b0;
        sel      = 1'b1;
        cache_en = 1'b0;
        doReset();
        runOp(OP_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, "nc_div_m7_2");
        runOp(OP_REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, "nc_rem_m7_2");

        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #500000;
        n_mismatched++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
